// File: rtl/core_sw_pkg.sv
// Shared types and defaults for the redundant-CPU switch controller.
package core_sw_pkg;

    // Bit 1 is the active CPU, bit 0 marks a hold-off state.
    typedef enum logic [1:0] {
        A_ACT  = 2'b00,
        A_HOLD = 2'b01,
        B_ACT  = 2'b10,
        B_HOLD = 2'b11
    } sw_state_e;

    localparam int unsigned ERR_W_DEF    = 8;
    localparam int unsigned DEBOUNCE_DEF = 16;
    localparam int unsigned HOLDOFF_DEF  = 1024;

    function automatic sw_state_e hold_of(input logic side);
        return side ? B_HOLD : A_HOLD;
    endfunction

    function automatic sw_state_e act_of(input logic side);
        return side ? B_ACT : A_ACT;
    endfunction

endpackage

// File: rtl/cpu_switch_ctrl_if.sv
// Health, force-command and status signals of the CPU switch controller.
interface cpu_switch_ctrl_if #(
    parameter int unsigned ERR_W = 8
);
    logic             io_a;
    logic             io_b;
    logic             force_swi;
    logic             com_swi;
    logic             switch;
    logic             sw_pulse;
    logic             hold;
    logic             err_a_f;
    logic             err_b_f;
    logic [ERR_W-1:0] a_err_num;
    logic [ERR_W-1:0] b_err_num;

    modport master (
        output io_a, io_b, force_swi, com_swi,
        input  switch, sw_pulse, hold, err_a_f, err_b_f, a_err_num, b_err_num
    );

    modport slave (
        input  io_a, io_b, force_swi, com_swi,
        output switch, sw_pulse, hold, err_a_f, err_b_f, a_err_num, b_err_num
    );
endinterface

// File: rtl/err_debounce.sv
// Synchronises one asynchronous health line, debounces it and flags error onsets.
module err_debounce #(
    parameter int unsigned DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_io,
    output logic o_err_f,
    output logic o_rise
);
    localparam int unsigned CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_err_f;
    logic          r_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_err_f <= 1'b0;
            r_err_q <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_io};
            r_err_q <= r_err_f;
            // Filtered io is ~r_err_f, so equality here means the sample disagrees.
            if (r_sync[1] == r_err_f) begin
                if (r_cnt == CNT_LAST) begin
                    r_err_f <= ~r_sync[1];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_err_f = r_err_f;
    assign o_rise  = r_err_f & ~r_err_q;

endmodule

// File: rtl/cpu_switch_ctrl.sv
// Chooses the active host CPU from debounced health, force commands and error history.
module cpu_switch_ctrl
    import core_sw_pkg::*;
#(
    parameter int unsigned ERR_W    = ERR_W_DEF,
    parameter int unsigned DEBOUNCE = DEBOUNCE_DEF,
    parameter int unsigned HOLDOFF  = HOLDOFF_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    cpu_switch_ctrl_if.slave bus
);
    localparam int unsigned HW = $clog2(HOLDOFF + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);

    logic             w_err_a, w_err_b, w_rise_a, w_rise_b;
    logic             w_side, w_own_err, w_oth_err, w_own_gt, w_sat;
    logic [ERR_W-1:0] w_a_nxt, w_b_nxt;

    sw_state_e        r_state;
    logic [HW-1:0]    r_hold_cnt;
    logic             r_sw_pulse;
    logic [ERR_W-1:0] r_a_cnt, r_b_cnt;

    err_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_io   (bus.io_a),
        .o_err_f(w_err_a),
        .o_rise (w_rise_a)
    );

    err_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_io   (bus.io_b),
        .o_err_f(w_err_b),
        .o_rise (w_rise_b)
    );

    // Halve both counters before an increment that would overflow either one.
    always_comb begin
        w_sat   = (w_rise_a && (&r_a_cnt)) || (w_rise_b && (&r_b_cnt));
        w_a_nxt = (w_sat ? (r_a_cnt >> 1) : r_a_cnt) + ERR_W'(w_rise_a);
        w_b_nxt = (w_sat ? (r_b_cnt >> 1) : r_b_cnt) + ERR_W'(w_rise_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_cnt <= '0;
            r_b_cnt <= '0;
        end else if (bus.force_swi) begin
            r_a_cnt <= '0;
            r_b_cnt <= '0;
        end else begin
            r_a_cnt <= w_a_nxt;
            r_b_cnt <= w_b_nxt;
        end
    end

    // Rules are written relative to the active side so A and B share one path.
    assign w_side    = r_state[1];
    assign w_own_err = w_side ? w_err_b : w_err_a;
    assign w_oth_err = w_side ? w_err_a : w_err_b;
    assign w_own_gt  = w_side ? (r_b_cnt > r_a_cnt) : (r_a_cnt > r_b_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= A_ACT;
            r_hold_cnt <= '0;
            r_sw_pulse <= 1'b0;
        end else begin
            r_sw_pulse <= 1'b0;
            if (bus.force_swi) begin
                if (r_state[0] || (bus.com_swi != w_side)) begin
                    r_state    <= hold_of(bus.com_swi);
                    r_hold_cnt <= '0;
                    r_sw_pulse <= (bus.com_swi != w_side);
                end
            end else if (r_state[0]) begin
                if (r_hold_cnt == HOLD_LAST) begin
                    r_state <= act_of(w_side);
                end else begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                end
            end else if ((w_own_err && !w_oth_err) ||
                         (!w_own_err && !w_oth_err && w_own_gt)) begin
                r_state    <= hold_of(~w_side);
                r_hold_cnt <= '0;
                r_sw_pulse <= 1'b1;
            end
        end
    end

    assign bus.switch    = r_state[1];
    assign bus.hold      = r_state[0];
    assign bus.sw_pulse  = r_sw_pulse;
    assign bus.err_a_f   = w_err_a;
    assign bus.err_b_f   = w_err_b;
    assign bus.a_err_num = r_a_cnt;
    assign bus.b_err_num = r_b_cnt;

endmodule

// File: tb/tb_cpu_switch_ctrl.sv
// Directed self-checking bench for cpu_switch_ctrl (DEBOUNCE=16, HOLDOFF=64).
module tb_cpu_switch_ctrl;

    localparam int unsigned HOLD = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   n_hold;

    always #5 clk = ~clk;

    cpu_switch_ctrl_if #(.ERR_W(8)) bus ();

    cpu_switch_ctrl #(
        .ERR_W   (8),
        .DEBOUNCE(16),
        .HOLDOFF (HOLD)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    // Counts cycles with hold high, starting from the current sample; bounded.
    task automatic count_hold(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (!bus.hold) break;
            n++;
            tick();
        end
    endtask

    task automatic pulse_io(input bit a, input bit b);
        if (a) bus.io_a = 1'b0;
        if (b) bus.io_b = 1'b0;
        tick_n(20);
        bus.io_a = 1'b1;
        bus.io_b = 1'b1;
        tick_n(20);
    endtask

    initial begin
        bus.io_a = 1'b1;
        bus.io_b = 1'b1;
        bus.force_swi = 1'b0;
        bus.com_swi = 1'b0;
        tick_n(3);
        check("rst_switch", bus.switch, 0);
        check("rst_hold", bus.hold, 0);
        check("rst_pulse", bus.sw_pulse, 0);
        check("rst_err_a_f", bus.err_a_f, 0);
        check("rst_a_num", bus.a_err_num, 0);
        check("rst_b_num", bus.b_err_num, 0);
        rst_n = 1'b1;
        tick_n(2);

        // Glitch shorter than the debounce window
        bus.io_a = 1'b0;
        tick_n(10);
        bus.io_a = 1'b1;
        tick_n(25);
        check("glitch_err_a_f", bus.err_a_f, 0);
        check("glitch_a_num", bus.a_err_num, 0);
        check("glitch_switch", bus.switch, 0);

        // CPU A fails: flag at edge 18, switch at edge 19
        bus.io_a = 1'b0;
        tick_n(17);
        check("a_fail_e17_flag", bus.err_a_f, 0);
        tick();
        check("a_fail_e18_flag", bus.err_a_f, 1);
        check("a_fail_e18_switch", bus.switch, 0);
        tick();
        check("a_fail_e19_switch", bus.switch, 1);
        check("a_fail_e19_pulse", bus.sw_pulse, 1);
        check("a_fail_e19_a_num", bus.a_err_num, 1);
        check("a_fail_e19_hold", bus.hold, 1);
        tick();
        check("a_fail_pulse_one", bus.sw_pulse, 0);
        count_hold(n_hold);
        check("a_fail_hold_len", n_hold + 1, HOLD);
        check("a_fail_after_switch", bus.switch, 1);

        // Both CPUs in error: no thrashing
        bus.io_b = 1'b0;
        tick_n(20);
        check("both_err_b_f", bus.err_b_f, 1);
        check("both_b_num", bus.b_err_num, 1);
        check("both_switch", bus.switch, 1);
        check("both_hold", bus.hold, 0);

        // A recovers while B is bad: automatic switch back to A
        bus.io_a = 1'b1;
        tick_n(18);
        check("a_ok_e18_switch", bus.switch, 1);
        tick();
        check("a_ok_e19_switch", bus.switch, 0);
        check("a_ok_e19_pulse", bus.sw_pulse, 1);
        check("a_ok_e19_hold", bus.hold, 1);
        check("a_ok_a_num", bus.a_err_num, 1);
        check("a_ok_b_num", bus.b_err_num, 1);

        // Force to A during A_HOLD restarts hold and clears counters
        tick_n(5);
        bus.force_swi = 1'b1;
        bus.com_swi = 1'b0;
        tick();
        bus.force_swi = 1'b0;
        check("force_hold_switch", bus.switch, 0);
        check("force_hold_a_num", bus.a_err_num, 0);
        check("force_hold_b_num", bus.b_err_num, 0);
        check("force_hold_pulse", bus.sw_pulse, 0);
        count_hold(n_hold);
        check("force_hold_len", n_hold, HOLD);
        check("force_after_switch", bus.switch, 0);

        // Force to B, then asynchronous reset in B_HOLD
        bus.force_swi = 1'b1;
        bus.com_swi = 1'b1;
        tick();
        bus.force_swi = 1'b0;
        bus.com_swi = 1'b0;
        check("force_b_switch", bus.switch, 1);
        check("force_b_hold", bus.hold, 1);
        check("force_b_pulse", bus.sw_pulse, 1);
        tick_n(3);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_switch", bus.switch, 0);
        check("async_rst_hold", bus.hold, 0);
        check("async_rst_err_b_f", bus.err_b_f, 0);
        bus.io_b = 1'b1;
        tick_n(2);
        rst_n = 1'b1;
        tick_n(3);

        // Saturation: preload A=255, B=100, then one more A edge
        for (int i = 0; i < 100; i++) pulse_io(1'b1, 1'b1);
        for (int i = 0; i < 155; i++) pulse_io(1'b1, 1'b0);
        check("preload_a_num", bus.a_err_num, 255);
        check("preload_b_num", bus.b_err_num, 100);
        pulse_io(1'b1, 1'b0);
        check("sat_a_num", bus.a_err_num, 128);
        check("sat_b_num", bus.b_err_num, 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
